id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_pkg.sv | 70 +++++++
 rtl/imm_gen.sv | 28 ++
 rtl/id_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode constants for the instruction-decode stage: opcode and ALU-op
// encodings, immediate-format selection, and the register-bus width macros.
`ifndef ID_STAGE_DEFINES_SV
`define ID_STAGE_DEFINES_SV
`define RegBus      XLEN-1:0
`define RegAddrBus  REG_AW-1:0
`define RegNum      (1 << REG_AW)
`endif

package id_stage_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    // Arithmetic codes are {1'b0, funct7[5], funct3}; branches are {2'b11, funct3}.
    typedef enum logic [4:0] {
        ALU_ADD   = 5'h00,
        ALU_SLL   = 5'h01,
        ALU_SLT   = 5'h02,
        ALU_SLTU  = 5'h03,
        ALU_XOR   = 5'h04,
        ALU_SRL   = 5'h05,
        ALU_OR    = 5'h06,
        ALU_AND   = 5'h07,
        ALU_SUB   = 5'h08,
        ALU_SRA   = 5'h0D,
        ALU_LUI   = 5'h10,
        ALU_JAL   = 5'h11,
        ALU_AUIPC = 5'h12,
        ALU_BEQ   = 5'h18,
        ALU_BNE   = 5'h19,
        ALU_BLT   = 5'h1C,
        ALU_BGE   = 5'h1D,
        ALU_BLTU  = 5'h1E,
        ALU_BGEU  = 5'h1F
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] opc);
        imm_type_e t;
        t = IMM_NONE;
        case (opc)
            OPC_LUI, OPC_AUIPC:              t = IMM_U;
            OPC_JAL:                         t = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM:  t = IMM_I;
            OPC_STORE:                       t = IMM_S;
            OPC_BRANCH:                      t = IMM_B;
            default:                         t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extractor; the format is chosen from the opcode
// and the 32-bit result is sign-extended to XLEN.
module imm_gen
    import id_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]   inst,
    output logic [`RegBus] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_type_of(inst[6:0]))
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes the fetched instruction, selects forwarded
// operands, detects load-use hazards and registers the result toward EX.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [31:0]        if_inst,
    input  logic [`RegBus]     if_pc,
    output logic               id_ready,
    output logic [`RegAddrBus] r_addr1,
    output logic [`RegAddrBus] r_addr2,
    output logic               read_request1,
    output logic               read_request2,
    input  logic [`RegBus]     r_data1,
    input  logic [`RegBus]     r_data2,
    input  logic               ex_fwd_we,
    input  logic [`RegAddrBus] ex_fwd_addr,
    input  logic [`RegBus]     ex_fwd_data,
    input  logic               ex_is_load,
    input  logic               mem_fwd_we,
    input  logic [`RegAddrBus] mem_fwd_addr,
    input  logic [`RegBus]     mem_fwd_data,
    input  logic               flush,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [`RegBus]     ex_pc,
    output logic [4:0]         ex_aluop,
    output logic [`RegBus]     ex_src1,
    output logic [`RegBus]     ex_src2,
    output logic [`RegBus]     ex_imm,
    output logic [`RegAddrBus] ex_rd,
    output logic               ex_we,
    output logic               ex_mem_rd,
    output logic               ex_mem_wr,
    output logic               ex_illegal
);

    typedef struct packed {
        logic               valid;
        logic [`RegBus]     pc;
        logic [4:0]         aluop;
        logic [`RegBus]     src1;
        logic [`RegBus]     src2;
        logic [`RegBus]     imm;
        logic [`RegAddrBus] rd;
        logic               we;
        logic               mem_rd;
        logic               mem_wr;
        logic               illegal;
    } ex_bundle_t;

    ex_bundle_t ex_q;
    ex_bundle_t ex_d;
    ex_bundle_t dec;

    logic [`RegBus]     imm;
    logic [`RegAddrBus] rd;
    logic [2:0]         funct3;
    logic               funct7_b5;
    logic               legal;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               writes_rd;
    logic               is_load;
    logic               is_store;
    logic [4:0]         aluop;
    logic               load_use;
    logic               transfer;

    logic [1:0][REG_AW-1:0] rs_addr;
    logic [1:0][XLEN-1:0]   rs_rdata;
    logic [1:0][XLEN-1:0]   operand;
    logic [1:0]             rs_req;
    logic [1:0]             rs_hazard;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (if_inst),
        .imm  (imm)
    );

    assign rd        = REG_AW'(if_inst[11:7]);
    assign funct3    = if_inst[14:12];
    assign funct7_b5 = if_inst[30];

    always_comb begin
        legal     = 1'b1;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        aluop     = ALU_ADD;
        case (if_inst[6:0])
            OPC_LUI: begin
                writes_rd = 1'b1;
                aluop     = ALU_LUI;
            end
            OPC_AUIPC: begin
                writes_rd = 1'b1;
                aluop     = ALU_AUIPC;
            end
            OPC_JAL: begin
                writes_rd = 1'b1;
                aluop     = ALU_JAL;
            end
            OPC_JALR: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                aluop     = ALU_JAL;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                aluop    = ALU_BEQ | {2'b00, funct3};
            end
            OPC_LOAD: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                is_load   = 1'b1;
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                is_store = 1'b1;
            end
            // Bit 30 of an I-type immediate is only an opcode modifier for SRAI.
            OPC_OP_IMM: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                aluop     = {1'b0, (funct3 == 3'b101) && funct7_b5, funct3};
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                aluop     = {1'b0, ((funct3 == 3'b000) || (funct3 == 3'b101)) && funct7_b5, funct3};
            end
            default: legal = 1'b0;
        endcase
    end

    assign r_addr1       = REG_AW'(if_inst[19:15]);
    assign r_addr2       = REG_AW'(if_inst[24:20]);
    assign read_request1 = if_valid && !flush && uses_rs1;
    assign read_request2 = if_valid && !flush && uses_rs2;

    assign rs_addr  = {r_addr2, r_addr1};
    assign rs_rdata = {r_data2, r_data1};
    assign rs_req   = {read_request2, read_request1};

    // A load still in EX has no data yet, so it never forwards; it stalls instead.
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
        assign operand[gi] =
            (rs_addr[gi] == '0)                                           ? '0 :
            (ex_fwd_we && !ex_is_load && (ex_fwd_addr == rs_addr[gi]))    ? ex_fwd_data :
            (mem_fwd_we && (mem_fwd_addr == rs_addr[gi]))                 ? mem_fwd_data :
                                                                            rs_rdata[gi];
        assign rs_hazard[gi] = rs_req[gi] && (ex_fwd_addr == rs_addr[gi]);
    end

    assign load_use = ex_q.valid && ex_is_load && (ex_fwd_addr != '0) && (|rs_hazard);
    assign id_ready = !rst && (!ex_q.valid || ex_ready) && !load_use && !flush;
    assign transfer = if_valid && id_ready;

    always_comb begin
        dec         = '0;
        dec.valid   = 1'b1;
        dec.pc      = if_pc;
        dec.aluop   = aluop;
        dec.src1    = uses_rs1 ? operand[0] : '0;
        dec.src2    = uses_rs2 ? operand[1] : '0;
        dec.imm     = imm;
        dec.rd      = writes_rd ? rd : '0;
        dec.we      = legal && writes_rd && (rd != '0);
        dec.mem_rd  = is_load;
        dec.mem_wr  = is_store;
        dec.illegal = !legal;
    end

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d.valid = 1'b0;
        end else if (ex_q.valid && !ex_ready) begin
            ex_d = ex_q;
        end else if (transfer) begin
            ex_d = dec;
        end else begin
            ex_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_pc      = ex_q.pc;
    assign ex_aluop   = ex_q.aluop;
    assign ex_src1    = ex_q.src1;
    assign ex_src2    = ex_q.src2;
    assign ex_imm     = ex_q.imm;
    assign ex_rd      = ex_q.rd;
    assign ex_we      = ex_q.we;
    assign ex_mem_rd  = ex_q.mem_rd;
    assign ex_mem_wr  = ex_q.mem_wr;
    assign ex_illegal = ex_q.illegal;

endmodule
